// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and its MAC.
package matmul_pkg;

    localparam int MM_N  = 2;
    localparam int MM_EW = 4;
    localparam int MM_OW = 8;

    // Wide enough to hold N products of two EW-bit operands without overflow
    localparam int ACCW = 2 * MM_EW + $clog2(MM_N);

    typedef logic [MM_EW-1:0] elem_t;
    typedef logic [ACCW-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    // Counter width helper: at least one bit even for a dimension of 1
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Registered multiply-accumulate; o_sum is the value the accumulator takes on
// the next enabled edge, so the caller can store a finished dot product directly.
module matmul_mac #(
    parameter int EW   = 4,
    parameter int ACCW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_clear,
    input  logic [EW-1:0]   i_a,
    input  logic [EW-1:0]   i_b,
    output logic [ACCW-1:0] o_sum
);

    logic [ACCW-1:0]   r_acc;
    logic [2*EW-1:0]   w_prod;

    assign w_prod = (2*EW)'(i_a) * (2*EW)'(i_b);
    assign o_sum  = (i_clear ? '0 : r_acc) + ACCW'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Load/compute/drain controller time-sharing one MAC over all N^3 products.
// Define MATMUL_SAT_EN to saturate c_out at 2^OW-1 instead of wrapping.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N  = MM_N,
    parameter int EW = MM_EW,
    parameter int OW = MM_OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          in_valid,
    input  logic [EW-1:0] a_in,
    input  logic [EW-1:0] b_in,
    input  logic          out_ready,
    output logic [OW-1:0] c_out,
    output logic          c_valid,
    output logic          c_last,
    output logic          busy,
    output logic          done
);

    localparam int ACC_W = 2 * EW + $clog2(N);
    localparam int NN    = N * N;
    localparam int IW    = clog2_min1(N);
    localparam int LW    = clog2_min1(NN);
    localparam logic [IW-1:0] LAST_I = IW'(N - 1);
    localparam logic [LW-1:0] LAST_L = LW'(NN - 1);

    state_t             r_state;
    logic [LW-1:0]      r_load_idx;
    logic [LW-1:0]      r_out_idx;
    logic [IW-1:0]      r_i;
    logic [IW-1:0]      r_j;
    logic [IW-1:0]      r_k;
    logic [EW-1:0]      r_a [NN];
    logic [EW-1:0]      r_b [NN];
    logic [ACC_W-1:0]   r_c [NN];
    logic               r_done;

    logic [LW-1:0]      w_a_idx;
    logic [LW-1:0]      w_b_idx;
    logic [LW-1:0]      w_c_idx;
    logic               w_mac_en;
    logic               w_mac_clr;
    logic [ACC_W-1:0]   w_mac_sum;
    logic [OW-1:0]      w_c_map [NN];

    assign w_a_idx   = LW'(int'(r_i) * N + int'(r_k));
    assign w_b_idx   = LW'(int'(r_k) * N + int'(r_j));
    assign w_c_idx   = LW'(int'(r_i) * N + int'(r_j));
    assign w_mac_en  = ena && (r_state == COMPUTE);
    assign w_mac_clr = (r_k == '0);

    matmul_mac #(
        .EW   (EW),
        .ACCW (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mac_en),
        .i_clear (w_mac_clr),
        .i_a     (r_a[w_a_idx]),
        .i_b     (r_b[w_b_idx]),
        .o_sum   (w_mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_load_idx <= '0;
            r_out_idx  <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_done     <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_c[n] <= '0;
            end
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a[0] <= a_in;
                        r_b[0] <= b_in;
                        if (NN == 1) begin
                            r_state <= COMPUTE;
                        end else begin
                            r_load_idx <= LW'(1);
                            r_state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_a[r_load_idx] <= a_in;
                        r_b[r_load_idx] <= b_in;
                        if (r_load_idx == LAST_L) begin
                            r_load_idx <= '0;
                            r_state    <= COMPUTE;
                        end else begin
                            r_load_idx <= r_load_idx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // k innermost; the dot product completes on the k==N-1 cycle
                    if (r_k == LAST_I) begin
                        r_c[w_c_idx] <= w_mac_sum;
                        r_k          <= '0;
                        if (r_j == LAST_I) begin
                            r_j <= '0;
                            if (r_i == LAST_I) begin
                                r_i       <= '0;
                                r_out_idx <= '0;
                                r_state   <= DRAIN;
                            end else begin
                                r_i <= r_i + 1'b1;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_out_idx == LAST_L) begin
                            r_out_idx <= '0;
                            r_state   <= IDLE;
                            r_done    <= 1'b1;
                        end else begin
                            r_out_idx <= r_out_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Map each full-width C entry to the OW-bit output format
    for (genvar gi = 0; gi < NN; gi++) begin : g_map
        if (ACC_W > OW) begin : g_narrow
`ifdef MATMUL_SAT_EN
            localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({OW{1'b1}});
            assign w_c_map[gi] = (r_c[gi] > SAT_MAX) ? {OW{1'b1}} : r_c[gi][OW-1:0];
`else
            logic w_unused_hi;
            assign w_unused_hi = ^r_c[gi][ACC_W-1:OW];
            assign w_c_map[gi] = r_c[gi][OW-1:0];
`endif
        end else begin : g_wide
            assign w_c_map[gi] = OW'(r_c[gi]);
        end
    end

    assign c_valid = (r_state == DRAIN);
    assign c_last  = c_valid && (r_out_idx == LAST_L);
    assign c_out   = c_valid ? w_c_map[r_out_idx] : '0;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed, table-driven bench for matmul_sequencer (N=2, EW=4, OW=8).
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       in_valid;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       out_ready;
    logic [7:0] c_out;
    logic       c_valid;
    logic       c_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_ready (out_ready),
        .c_out     (c_out),
        .c_valid   (c_valid),
        .c_last    (c_last),
        .busy      (busy),
        .done      (done)
    );

    // Element e of A/B is nibble e; element e of C is byte e (row-major)
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          gap;
        int          stall;
        int          ena_hold;
        logic [31:0] c;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_c_valid"}, 32'(c_valid), 32'd0);
        check({tag, "_c_out"},   32'(c_out),   32'd0);
        check({tag, "_c_last"},  32'(c_last),  32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cnt;
        logic [7:0] exp_c;
        for (int e = 0; e < 4; e++) begin
            in_valid = 1'b1;
            a_in     = v.a[e*4 +: 4];
            b_in     = v.b[e*4 +: 4];
            step();
            check("busy_load", 32'(busy), 32'd1);
            if (e == 1 && v.gap > 0) begin
                in_valid = 1'b0;
                a_in     = 4'hF;
                b_in     = 4'hF;
                repeat (v.gap) begin
                    step();
                    check("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
        // Junk in_valid during compute must be ignored
        in_valid = 1'b1;
        a_in     = 4'hE;
        b_in     = 4'hD;
        cnt      = 0;
        while (c_valid !== 1'b1 && cnt < 100) begin
            ena = (v.ena_hold > 0 && cnt >= 3 && cnt < 3 + v.ena_hold) ? 1'b0 : 1'b1;
            step();
            cnt++;
        end
        ena      = 1'b1;
        in_valid = 1'b0;
        check("latency", 32'(cnt), 32'(v.lat));
        if (cnt >= 100) return;

        for (int e = 0; e < 4; e++) begin
            exp_c = v.c[e*8 +: 8];
            if (e == 0 && v.stall > 0) begin
                out_ready = 1'b0;
                repeat (v.stall) begin
                    step();
                    check("stall_valid", 32'(c_valid), 32'd1);
                    check("stall_hold",  32'(c_out),   32'(exp_c));
                end
            end
            out_ready = 1'b1;
            check("c_valid", 32'(c_valid), 32'd1);
            check("c_out",   32'(c_out),   32'(exp_c));
            check("c_last",  32'(c_last),  (e == 3) ? 32'd1 : 32'd0);
            $display("vec %0d C[%0d] = %0d (expected %0d)", id, e, c_out, exp_c);
            step();
        end
        out_ready = 1'b0;
        check("done_pulse",   32'(done),    32'd1);
        check("c_valid_drop", 32'(c_valid), 32'd0);
        check("busy_end",     32'(busy),    32'd0);
        step();
        check("done_clear",   32'(done),    32'd0);
    endtask

    initial begin
        logic [31:0] big_c;
`ifdef MATMUL_SAT_EN
        big_c = 32'hFFFF_FFFF;
`else
        big_c = 32'hC2C2_C2C2;
`endif
        //           a         b         gap stall ena  c (C11,C10,C01,C00)  lat
        vecs[0] = '{16'h4321, 16'h8765, 0,  0,    0,   32'h322B_1613, 8};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 0,  0,    0,   big_c,         8};
        vecs[2] = '{16'h4321, 16'h8765, 2,  0,    0,   32'h322B_1613, 8};
        vecs[3] = '{16'h4321, 16'h8765, 0,  3,    0,   32'h322B_1613, 8};
        vecs[4] = '{16'h4321, 16'h8765, 0,  0,    5,   32'h322B_1613, 13};

        rst       = 1'b1;
        ena       = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], v);
        end

        // Reset in the middle of a load, then a fresh identity * B run
        in_valid = 1'b1;
        a_in     = 4'd9;
        b_in     = 4'd9;
        step();
        step();
        check("busy_pre_rst", 32'(busy), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        run_vec('{16'h1001, 16'h8765, 0, 0, 0, 32'h0807_0605, 8}, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
